i2s_slave_encoder: RTL



---
 rtl/i2s_pkg.sv | 25 ++
 rtl/i2s_edge_sync.sv | 44 ++++
 rtl/i2s_slave_encoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default geometry and frame-lock state.
package i2s_pkg;

  localparam int unsigned I2S_WIDTH       = 16;
  localparam int unsigned I2S_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    NOSYNC = 2'd0,
    HALF   = 2'd1,
    LOCKED = 2'd2
  } frame_state_t;

  // Frame-lock progression on a channel edge: a left start arms the
  // framer, the following right start completes it. A right edge seen
  // while unsynchronised does not count towards lock.
  function automatic frame_state_t frame_next(input frame_state_t cur,
                                              input logic         ws_new);
    frame_state_t nxt;
    nxt = cur;
    if (!ws_new && (cur == NOSYNC)) nxt = HALF;
    if (ws_new && (cur == HALF))    nxt = LOCKED;
    return nxt;
  endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Synchroniser for the external {sck, ws} pair with a registered sck-fall pulse.
// Both signals share one pipeline so their relative alignment is preserved.
module i2s_edge_sync
  import i2s_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = I2S_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic ws,
  output logic ws_s,
  output logic fall
);

  // pipe[k] = {sck, ws} after k+1 flops
  logic [1:0] pipe [SYNC_STAGES];
  logic       sck_pre_last;

  // The fall pulse is registered together with the last stage, so it is
  // high in exactly the first cycle where the synced sck reads 0.
  generate
    if (SYNC_STAGES > 1) begin : g_multi
      assign sck_pre_last = pipe[SYNC_STAGES-2][1];
    end else begin : g_single
      assign sck_pre_last = sck;
    end
  endgenerate

  // Shift both signals through the synchroniser and flag sck 1->0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) pipe[i] <= '0;
      fall <= 1'b0;
    end else begin
      pipe[0] <= {sck, ws};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) pipe[i] <= pipe[i-1];
      fall <= pipe[SYNC_STAGES-1][1] & ~sck_pre_last;
    end
  end

  assign ws_s = pipe[SYNC_STAGES-1][0];

endmodule

// File: rtl/i2s_slave_encoder.sv
// I2S slave transmitter: serialises a stereo pair onto sd, timed by an
// externally mastered sck/ws, with frame-lock and loss-of-clock detection.
module i2s_slave_encoder
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH          = I2S_WIDTH,
  parameter int unsigned SYNC_STAGES    = I2S_SYNC_STAGES,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] audio_l,
  input  logic [WIDTH-1:0] audio_r,
  input  logic             sck,
  input  logic             ws,
  output logic             sd,
  output logic             sample_strobe,
  output logic             locked
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BITS_FULL = BW'(WIDTH);
  localparam logic [TW-1:0] TO_SAT    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic             ws_s;
  logic             fall;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hold_r;
  logic [BW-1:0]    bits_left;
  logic             ws_last;
  logic [TW-1:0]    to_cnt;
  logic             timeout_hit;
  frame_state_t     state;
  frame_state_t     edge_state;

  i2s_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .sck   (sck),
    .ws    (ws),
    .ws_s  (ws_s),
    .fall  (fall)
  );

  assign timeout_hit = !fall && (to_cnt == TO_LAST);
  assign edge_state  = frame_next(state, ws_s);

  // Cycles since the last sck fall, saturating once the link is declared lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (fall) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_SAT) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Serialiser and frame-lock FSM: shift on every fall, reload on channel
  // edges (the reload overrides the shift of the same fall), drop on timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sd            <= 1'b0;
      sample_strobe <= 1'b0;
      locked        <= 1'b0;
      sh            <= '0;
      hold_r        <= '0;
      bits_left     <= '0;
      ws_last       <= 1'b0;
      state         <= NOSYNC;
    end else begin
      sample_strobe <= 1'b0;
      if (fall) begin
        if (bits_left != '0) begin
          sd        <= sh[WIDTH-1];
          sh        <= {sh[WIDTH-2:0], 1'b0};
          bits_left <= bits_left - BW'(1);
        end else begin
          sd <= 1'b0;
        end
        if (ws_s != ws_last) begin
          if (!ws_s) begin
            hold_r        <= audio_r;
            sh            <= audio_l;
            sample_strobe <= 1'b1;
          end else begin
            sh <= hold_r;
          end
          bits_left <= BITS_FULL;
          state     <= edge_state;
          locked    <= (edge_state == LOCKED);
        end
        ws_last <= ws_s;
      end else if (timeout_hit) begin
        state     <= NOSYNC;
        locked    <= 1'b0;
        bits_left <= '0;
        sd        <= 1'b0;
      end
    end
  end

endmodule
